// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot loader: FSM states, error codes,
// header tag and header field positions.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_INSTR,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MAGIC    = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_CHECKSUM = 2'b11;

  localparam logic [7:0] MAGIC_TAG      = 8'hA5;
  localparam int         IMEM_WORDS_DEF = 256;
  localparam int         DMEM_BYTES_DEF = 32;

  // Header word layout (little-endian assembled word).
  localparam int HDR_NI_LSB  = 0;
  localparam int HDR_NI_MSB  = 8;
  localparam int HDR_ND_LSB  = 16;
  localparam int HDR_ND_MSB  = 21;
  localparam int HDR_TAG_LSB = 24;
  localparam int HDR_TAG_MSB = 31;

  // First payload state after a valid header: instructions, then data, then checksum.
  function automatic state_t payload_state(input logic has_instr, input logic has_data);
    if (has_instr)     return ST_INSTR;
    else if (has_data) return ST_DATA;
    else               return ST_CHK;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four little-endian bytes into a 32-bit word. The completed word
// is presented combinationally while its fourth byte is being accepted,
// so the consumer can register it on that same edge.
module word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  // Shift each accepted byte in from the top; the 2-bit count wraps per word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_byte_valid) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      r_shift <= {i_byte, r_shift[23:8]};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word       = {i_byte, r_shift};
  assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses header, instruction words, data bytes and an XOR
// checksum from a byte stream, writes the CPU memories, then raises start_o.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int         DMEM_BYTES = DMEM_BYTES_DEF,
  parameter logic [7:0] MAGIC      = MAGIC_TAG
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [7:0]  imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        dmem_we_o,
  output logic [4:0]  dmem_addr_o,
  output logic [7:0]  dmem_data_o,
  output logic        start_o,
  output logic        busy_o,
  output logic [1:0]  err_o,
  output logic [8:0]  words_loaded_o
);

  localparam logic [9:0] IMEM_LIMIT = 10'(IMEM_WORDS);
  localparam logic [6:0] DMEM_LIMIT = 7'(DMEM_BYTES);

  state_t      r_state, w_state_nxt;
  logic [1:0]  w_err_code;
  logic        w_accept;
  logic        w_asm_valid;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic [8:0]  w_hdr_ni;
  logic [5:0]  w_hdr_nd;
  logic [7:0]  w_hdr_tag;
  logic        w_last_word;
  logic        w_last_data;

  logic [8:0]  r_ni;
  logic [5:0]  r_nd;
  logic [8:0]  r_words;
  logic [5:0]  r_dcnt;
  logic [7:0]  r_csum;
  logic        r_busy;
  logic [1:0]  r_err;
  logic        r_imem_we;
  logic [7:0]  r_imem_addr;
  logic [31:0] r_imem_data;
  logic        r_dmem_we;
  logic [4:0]  r_dmem_addr;
  logic [7:0]  r_dmem_data;

  assign w_accept    = rx_valid_i && rx_ready_o;
  assign w_asm_valid = w_accept && (r_state == ST_HDR || r_state == ST_INSTR);

  word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_byte_valid (w_asm_valid),
    .i_byte       (rx_data_i),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  assign w_hdr_ni    = w_word[HDR_NI_MSB:HDR_NI_LSB];
  assign w_hdr_nd    = w_word[HDR_ND_MSB:HDR_ND_LSB];
  assign w_hdr_tag   = w_word[HDR_TAG_MSB:HDR_TAG_LSB];
  assign w_last_word = (r_words + 9'd1) == r_ni;
  assign w_last_data = (r_dcnt + 6'd1) == r_nd;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_HDR;
    else        r_state <= w_state_nxt;
  end

  // Next-state and error-code selection; bad tag outranks overflow.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    w_state_nxt = r_state;
    w_err_code  = ERR_NONE;
    unique case (r_state)
      ST_HDR: begin
        if (w_word_valid) begin
          if (w_hdr_tag != MAGIC) begin
            w_state_nxt = ST_ERR;
            w_err_code  = ERR_MAGIC;
          end else if ({1'b0, w_hdr_ni} > IMEM_LIMIT || {1'b0, w_hdr_nd} > DMEM_LIMIT) begin
            w_state_nxt = ST_ERR;
            w_err_code  = ERR_OVERFLOW;
          end else begin
            w_state_nxt = payload_state(w_hdr_ni != '0, w_hdr_nd != '0);
          end
        end
      end
      ST_INSTR: if (w_word_valid && w_last_word) w_state_nxt = payload_state(1'b0, r_nd != '0);
      ST_DATA:  if (w_accept && w_last_data)     w_state_nxt = ST_CHK;
      ST_CHK: begin
        if (w_accept) begin
          if (rx_data_i == r_csum) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ERR;
            w_err_code  = ERR_CHECKSUM;
          end
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // State-decoded outputs; ready is forced low while reset is held.
  always_comb begin
    rx_ready_o = rst_i && (r_state == ST_HDR || r_state == ST_INSTR ||
                           r_state == ST_DATA || r_state == ST_CHK);
    start_o    = (r_state == ST_DONE);
  end

  // Datapath: header capture, checksum, write strobes, counters, sticky error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ni        <= '0;
      r_nd        <= '0;
      r_words     <= '0;
      r_dcnt      <= '0;
      r_csum      <= '0;
      r_busy      <= 1'b0;
      r_err       <= ERR_NONE;
      r_imem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_dmem_we   <= 1'b0;
      r_dmem_addr <= '0;
      r_dmem_data <= '0;
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      if (w_accept && r_state != ST_CHK) r_csum <= r_csum ^ rx_data_i;
      if (w_accept) r_busy <= !(w_state_nxt == ST_DONE || w_state_nxt == ST_ERR);
      if (r_state == ST_HDR && w_word_valid) begin
        r_ni <= w_hdr_ni;
        r_nd <= w_hdr_nd;
      end
      if (r_state == ST_INSTR && w_word_valid) begin
        r_imem_we   <= 1'b1;
        r_imem_addr <= r_words[7:0];
        r_imem_data <= w_word;
        r_words     <= r_words + 9'd1;
      end
      if (r_state == ST_DATA && w_accept) begin
        r_dmem_we   <= 1'b1;
        r_dmem_addr <= r_dcnt[4:0];
        r_dmem_data <= rx_data_i;
        r_dcnt      <= r_dcnt + 6'd1;
      end
      if (w_state_nxt == ST_ERR && r_state != ST_ERR) r_err <= w_err_code;
    end
  end

  assign imem_we_o      = r_imem_we;
  assign imem_addr_o    = r_imem_addr;
  assign imem_data_o    = r_imem_data;
  assign dmem_we_o      = r_dmem_we;
  assign dmem_addr_o    = r_dmem_addr;
  assign dmem_data_o    = r_dmem_data;
  assign busy_o         = r_busy;
  assign err_o          = r_err;
  assign words_loaded_o = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: images are built from the stream
// format rules, driven with optional valid gaps, and observed memory writes
// are compared against the expected write lists.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, imem_we, dmem_we, start, busy;
  logic [7:0]  imem_addr, dmem_data;
  logic [31:0] imem_data;
  logic [4:0]  dmem_addr;
  logic [1:0]  err;
  logic [8:0]  words_loaded;
  logic [68:0] all_outs;

  imem_loader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .imem_we_o      (imem_we),
    .imem_addr_o    (imem_addr),
    .imem_data_o    (imem_data),
    .dmem_we_o      (dmem_we),
    .dmem_addr_o    (dmem_addr),
    .dmem_data_o    (dmem_data),
    .start_o        (start),
    .busy_o         (busy),
    .err_o          (err),
    .words_loaded_o (words_loaded)
  );

  assign all_outs = {rx_ready, imem_we, imem_addr, imem_data, dmem_we, dmem_addr,
                     dmem_data, start, busy, err, words_loaded};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed writes: only the monitor appends; tests index from a base.
  logic [39:0] obs_imem[$];
  logic [12:0] obs_dmem[$];
  int          busy_cnt = 0;
  int          imem_base, dmem_base, busy_base;

  always @(negedge clk) begin
    if (imem_we) obs_imem.push_back({imem_addr, imem_data});
    if (dmem_we) obs_dmem.push_back({dmem_addr, dmem_data});
    if (busy)    busy_cnt++;
  end

  // Reference model state.
  logic [7:0]  stream[$];
  logic [31:0] words_in[$];
  logic [7:0]  data_in[$];
  logic [39:0] exp_imem[$];
  logic [12:0] exp_dmem[$];
  logic [1:0]  exp_err;
  logic        exp_start;
  int          exp_words;
  logic        pre_start;

  task automatic fill_payload(input int ni, input int nd);
    words_in.delete();
    data_in.delete();
    for (int i = 0; i < ni; i++) words_in.push_back($urandom);
    for (int j = 0; j < nd; j++) data_in.push_back(8'($urandom));
  endtask

  // Build the byte stream and the expected outcome from the format rules.
  task automatic build_image(input int ni, input int nd, input logic [7:0] tag,
                             input logic [7:0] flip, input logic [31:0] rsv);
    logic [31:0] hdr;
    logic [7:0]  x;
    stream.delete();
    exp_imem.delete();
    exp_dmem.delete();
    exp_words = 0;
    exp_start = 1'b0;
    hdr = (tag << 24) | ((nd & 63) << 16) | (ni & 511) | (rsv & 32'h00C0FE00);
    for (int k = 0; k < 4; k++) stream.push_back(hdr[8*k +: 8]);
    if (tag != 8'hA5) begin
      exp_err = 2'b01;
      for (int k = 0; k < 3; k++) stream.push_back(8'($urandom));
      return;
    end
    if (ni > 256 || nd > 32) begin
      exp_err = 2'b10;
      for (int k = 0; k < 3; k++) stream.push_back(8'($urandom));
      return;
    end
    for (int i = 0; i < ni; i++) begin
      for (int k = 0; k < 4; k++) stream.push_back(words_in[i][8*k +: 8]);
      exp_imem.push_back({8'(i % 256), words_in[i]});
    end
    exp_words = ni;
    for (int j = 0; j < nd; j++) begin
      stream.push_back(data_in[j]);
      exp_dmem.push_back({5'(j), data_in[j]});
    end
    x = '0;
    foreach (stream[k]) x = x ^ stream[k];
    stream.push_back(x ^ flip);
    exp_err   = (flip != 0) ? 2'b11 : 2'b00;
    exp_start = (flip == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    imem_base = obs_imem.size();
    dmem_base = obs_dmem.size();
    busy_base = busy_cnt;
  endtask

  // gap_mode: 0 none, 1 one idle cycle per byte, 2 random 0..3 idle cycles.
  task automatic send_bytes(input int first, input int count, input int gap_mode);
    int gap;
    for (int k = first; k < first + count; k++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 3));
      repeat (gap) begin
        @(negedge clk);
        rx_valid = 1'b0;
      end
      @(negedge clk);
      rx_valid  = 1'b1;
      rx_data   = stream[k];
      pre_start = start;
    end
  endtask

  // Drive the whole stream; returns #1 after the edge accepting the last byte.
  task automatic run_load(input int gap_mode);
    send_bytes(0, stream.size(), gap_mode);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  function automatic int imem_diff();
    int d = 0;
    if (obs_imem.size() - imem_base != exp_imem.size()) return 1000;
    foreach (exp_imem[k]) if (obs_imem[imem_base + k] !== exp_imem[k]) d++;
    return d;
  endfunction

  function automatic int dmem_diff();
    int d = 0;
    if (obs_dmem.size() - dmem_base != exp_dmem.size()) return 1000;
    foreach (exp_dmem[k]) if (obs_dmem[dmem_base + k] !== exp_dmem[k]) d++;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_outs !== 69'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", all_outs);
    end
    rx_valid = 1'b0;
    rst = 1'b1;
    imem_base = obs_imem.size();
    dmem_base = obs_dmem.size();
    @(negedge clk);
    n_cmp++;
    if ({rx_ready, busy, start, err} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_release: ready/busy/start/err got %b want 10000", {rx_ready, busy, start, err});
    end
  endtask

  task automatic test_spec_image();
    do_reset();
    words_in.delete();
    words_in.push_back(32'h8C020000);
    words_in.push_back(32'h00000000);
    data_in.delete();
    build_image(2, 0, 8'hA5, 8'h00, 32'h00000200);
    run_load(0);
    n_cmp++;
    if ({pre_start, start, err} !== 4'b0100) begin
      n_bad++;
      $display("FAIL spec_start: pre/start/err got %b want 0100", {pre_start, start, err});
    end
    settle();
    n_cmp++;
    if (imem_diff() !== 0) begin
      n_bad++;
      $display("FAIL spec_imem: %0d writes differ, got %0d writes want 2", imem_diff(), obs_imem.size() - imem_base);
    end
    n_cmp++;
    if (words_loaded !== 9'd2) begin
      n_bad++;
      $display("FAIL spec_words: got %0d want 2", words_loaded);
    end
    n_cmp++;
    if (busy_cnt == busy_base || busy !== 1'b0 || rx_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL spec_busy_ready: busy cycles %0d busy %b ready %b want >0,0,0", busy_cnt - busy_base, busy, rx_ready);
    end
  endtask

  task automatic test_instr_data();
    do_reset();
    fill_payload(1, 0);
    data_in.push_back(8'h05);
    build_image(1, 1, 8'hA5, 8'h00, 32'h0);
    run_load(2);
    n_cmp++;
    if ({start, err} !== 3'b100) begin
      n_bad++;
      $display("FAIL idata_start: start/err got %b want 100", {start, err});
    end
    settle();
    n_cmp++;
    if (dmem_diff() !== 0 || imem_diff() !== 0) begin
      n_bad++;
      $display("FAIL idata_writes: dmem diff %0d imem diff %0d want 0 0", dmem_diff(), imem_diff());
    end
  endtask

  task automatic test_bad_magic();
    do_reset();
    build_image(2, 1, 8'h5A, 8'h00, 32'h0);
    run_load(0);
    settle();
    n_cmp++;
    if ({err, rx_ready, start, busy} !== 5'b01000) begin
      n_bad++;
      $display("FAIL magic_state: err/ready/start/busy got %b want 01000", {err, rx_ready, start, busy});
    end
    n_cmp++;
    if (obs_imem.size() != imem_base || obs_dmem.size() != dmem_base) begin
      n_bad++;
      $display("FAIL magic_writes: got %0d strobes want 0", obs_imem.size() - imem_base + obs_dmem.size() - dmem_base);
    end
  endtask

  task automatic test_overflow();
    int ni_tab[3] = '{257, 1, 300};
    int nd_tab[3] = '{0, 33, 0};
    logic [7:0] tag_tab[3] = '{8'hA5, 8'hA5, 8'h00};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      build_image(ni_tab[t], nd_tab[t], tag_tab[t], 8'h00, 32'h0);
      run_load(0);
      settle();
      n_cmp++;
      if (err !== exp_err || start !== 1'b0 || obs_imem.size() != imem_base) begin
        n_bad++;
        $display("FAIL overflow_%0d: err %b start %b writes %0d want err %b start 0 writes 0",
                 t, err, start, obs_imem.size() - imem_base, exp_err);
      end
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    fill_payload(3, 4);
    build_image(3, 4, 8'hA5, 8'h01, 32'h0);
    run_load(1);
    settle();
    n_cmp++;
    if ({err, start} !== 3'b110) begin
      n_bad++;
      $display("FAIL csum_state: err/start got %b want 110", {err, start});
    end
    n_cmp++;
    if (imem_diff() !== 0 || dmem_diff() !== 0 || words_loaded !== 9'd3) begin
      n_bad++;
      $display("FAIL csum_writes: imem diff %0d dmem diff %0d words %0d want 0 0 3", imem_diff(), dmem_diff(), words_loaded);
    end
  endtask

  task automatic test_random();
    int ni, nd;
    for (int it = 0; it < 8; it++) begin
      ni = (it == 0) ? 0 : int'($urandom_range(0, 12));
      nd = (it == 0) ? 0 : int'($urandom_range(0, 32));
      do_reset();
      fill_payload(ni, nd);
      build_image(ni, nd, 8'hA5, 8'h00, $urandom);
      run_load(2);
      settle();
      n_cmp++;
      if (start !== 1'b1 || err !== 2'b00 || words_loaded !== 9'(exp_words) ||
          imem_diff() !== 0 || dmem_diff() !== 0) begin
        n_bad++;
        $display("FAIL random_%0d ni=%0d nd=%0d: start %b err %b words %0d idiff %0d ddiff %0d want 1 00 %0d 0 0",
                 it, ni, nd, start, err, words_loaded, imem_diff(), dmem_diff(), exp_words);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    fill_payload(256, 32);
    build_image(256, 32, 8'hA5, 8'h00, 32'h0);
    run_load(0);
    settle();
    n_cmp++;
    if (start !== 1'b1 || words_loaded !== 9'd256 || imem_addr !== 8'hFF || dmem_addr !== 5'd31) begin
      n_bad++;
      $display("FAIL full_state: start %b words %0d iaddr %0d daddr %0d want 1 256 255 31",
               start, words_loaded, imem_addr, dmem_addr);
    end
    n_cmp++;
    if (imem_diff() !== 0 || dmem_diff() !== 0) begin
      n_bad++;
      $display("FAIL full_writes: imem diff %0d dmem diff %0d want 0 0", imem_diff(), dmem_diff());
    end
  endtask

  task automatic test_gaps_reset();
    int got;
    do_reset();
    fill_payload(5, 2);
    build_image(5, 2, 8'hA5, 8'h00, 32'h0);
    send_bytes(0, 16, 1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== 69'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h want 0", all_outs);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    got = obs_imem.size() - imem_base;
    n_cmp++;
    if (got != 3 || obs_imem[imem_base] !== exp_imem[0] || obs_imem[imem_base + 1] !== exp_imem[1] ||
        obs_imem[imem_base + 2] !== exp_imem[2]) begin
      n_bad++;
      $display("FAIL midreset_writes: got %0d writes want 3 matching", got);
    end
    n_cmp++;
    if ({rx_ready, busy, words_loaded} !== {1'b1, 1'b0, 9'd0}) begin
      n_bad++;
      $display("FAIL midreset_idle: ready %b busy %b words %0d want 1 0 0", rx_ready, busy, words_loaded);
    end
    imem_base = obs_imem.size();
    dmem_base = obs_dmem.size();
    fill_payload(4, 3);
    build_image(4, 3, 8'hA5, 8'h00, 32'h0);
    run_load(1);
    settle();
    n_cmp++;
    if (start !== 1'b1 || err !== 2'b00 || imem_diff() !== 0 || dmem_diff() !== 0) begin
      n_bad++;
      $display("FAIL midreset_reload: start %b err %b idiff %0d ddiff %0d want 1 00 0 0",
               start, err, imem_diff(), dmem_diff());
    end
  endtask

  initial begin
    test_reset();
    test_spec_image();
    test_instr_data();
    test_bad_magic();
    test_overflow();
    test_bad_checksum();
    test_random();
    test_full();
    test_gaps_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Hardware boot loader. Receives a byte stream carrying a program image and data-memory preload.
- Writes instruction words into Instruction_Memory (256 x 32 bit) and bytes into Data_Memory (32 x 8 bit).
- After a checksum-verified load, asserts start_o, which drives the CPU start_i.
- Sits between the external byte link and the CPU memories, in the slot currently filled by simulation-only memory preload.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words
- DMEM_BYTES, 32, data memory depth in bytes
- MAGIC, 8'hA5, required header tag in bits [31:24]

Ports:
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  reset, asynchronous, active-low
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  loader accepts a byte; transfer occurs when valid&ready at a rising edge
- imem_we_o  out  1  instruction memory write strobe
- imem_addr_o  out  8  word index
- imem_data_o  out  32  instruction word
- dmem_we_o  out  1  data memory write strobe
- dmem_addr_o  out  5  byte address
- dmem_data_o  out  8  data byte
- start_o  out  1  CPU start; level signal
- busy_o  out  1  load in progress
- err_o  out  2  00 none, 01 bad magic, 10 count overflow, 11 checksum mismatch
- words_loaded_o  out  9  instruction words written so far

Behaviour:
- Reset (rst_i=0, async) clears every output to 0, state=HDR, all counters 0, checksum accumulator 0. Reset mid-load aborts the load. No further writes occur. Memory contents already written are left untouched.
- Stream format, bytes little-endian within words:
  - 4-byte header: [8:0] instruction count NI; [21:16] data byte count ND; [31:24] MAGIC.
  - NI instruction words (4 bytes each).
  - ND data bytes.
  - 1 checksum byte = XOR of all preceding bytes, header included.
- States: HDR, INSTR, DATA, CHK, DONE, ERR.
- rx_ready_o=1 in HDR/INSTR/DATA/CHK. rx_ready_o=0 in DONE/ERR and during reset.
- busy_o=1 from the first accepted byte until entry to DONE or ERR.
- Every accepted byte except the checksum byte is XORed into the accumulator.
- HDR, on the 4th header byte:
  - MAGIC mismatch -> ERR, err_o=01.
  - NI>IMEM_WORDS or ND>DMEM_BYTES -> ERR, err_o=10. Magic has priority over overflow.
  - Otherwise go to INSTR if NI>0, else DATA if ND>0, else CHK.
- INSTR:
  - Bytes assemble into a word. On the edge accepting byte 3, register imem_we_o=1 with imem_addr_o=current index and imem_data_o=assembled word.
  - Strobe lasts exactly one cycle. Index and words_loaded_o increment on the same edge.
  - After word NI-1, go to DATA if ND>0, else CHK.
- DATA: each accepted byte registers dmem_we_o=1 for one cycle with dmem_addr_o=byte index and dmem_data_o=byte. After byte ND-1, go to CHK.
- CHK:
  - Byte equals accumulator -> DONE.
  - Otherwise -> ERR, err_o=11.
- DONE: start_o=1, held until reset. No writes.
- ERR: err_o sticky, start_o stays 0. Ignore input until reset.
- Write latency: strobe is valid in the cycle after the accepting edge; the memory captures it on the following edge.
- Back-pressure is never applied mid-load. rx_valid_i gaps of any length are allowed, and state holds while rx_valid_i=0.
- imem_addr_o and dmem_addr_o hold their last value when the strobe is low.
- NI=256 wraps the 8-bit index to 0 after the final write without issue; words_loaded_o reads 256.

Decomposition:
- Shared package holds:
  - the state enum;
  - err_o code constants;
  - MAGIC;
  - header field bit positions.
- One natural sub-module, word_assembler: shift-in of 4 bytes with a byte counter, emitting a 32-bit word plus a one-cycle word_valid. It is reused for the header and instruction words.

Test Plan:
- Header A5_00_02_02 (NI=2, ND=0), words 0x8C020000, 0x00000000, correct checksum -> imem[0], imem[1] written, words_loaded_o=2, start_o=1 one cycle after the checksum byte, err_o=00.
- NI=1, ND=1, data byte 0x05 -> dmem[0]=5 with one dmem_we_o pulse; start_o=1.
- Header with tag 0x5A -> err_o=01, rx_ready_o=0, no write strobes, start_o stays 0.
- NI=257 -> err_o=10. Separately, ND=33 -> err_o=10.
- Correct image with checksum XOR 0x01 -> all writes occur, err_o=11, start_o=0.
- rx_valid_i toggled 1/0 every cycle, then rst_i pulsed low after 3 instruction words -> writes unaffected by gaps; after reset all outputs are 0, state is HDR, and a fresh image loads correctly.
